// File: rtl/snake_body_engine.sv
// Snake body store and movement engine: segment shift register, direction filter,
// wall/self collision detection and a registered per-cell occupancy query.
module snake_body_engine #(
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned INIT_LEN  = 2,
    parameter int unsigned LEN_W     = 6,
    parameter int unsigned GRID_W    = 160,
    parameter int unsigned GRID_H    = 120,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned WRAP_MODE = 1,
    parameter int unsigned START_X   = 80,
    parameter int unsigned START_Y   = 100
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLEAR,
    input  logic             STEP,
    input  logic [1:0]       NAV_STATE,
    input  logic             GROW,
    input  logic [X_W-1:0]   QUERY_X,
    input  logic [Y_W-1:0]   QUERY_Y,
    output logic             QUERY_HIT,
    output logic             QUERY_HEAD,
    output logic [X_W-1:0]   HEAD_X,
    output logic [Y_W-1:0]   HEAD_Y,
    output logic [LEN_W-1:0] LENGTH,
    output logic             SELF_HIT,
    output logic             WALL_HIT,
    output logic             MOVE_DONE
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    logic [X_W-1:0] seg_x [MAX_LEN];
    logic [Y_W-1:0] seg_y [MAX_LEN];
    dir_t           cur_dir;
    logic           grow_pending;

    dir_t             new_dir_c;
    logic [X_W-1:0]   next_x_c;
    logic [Y_W-1:0]   next_y_c;
    logic             off_grid_c;
    logic             grow_eff_c;
    logic [LEN_W-1:0] hit_lim_c;
    logic             body_hit_c;
    logic             q_hit_c;
    logic             wall_stop_c;
    logic             frozen_c;

    assign HEAD_X = seg_x[0];
    assign HEAD_Y = seg_y[0];

    // Direction filter, next-head calculation, collision and query compare.
    always_comb begin
        new_dir_c  = dir_t'(NAV_STATE);
        next_x_c   = seg_x[0];
        next_y_c   = seg_y[0];
        off_grid_c = 1'b0;
        body_hit_c = 1'b0;
        q_hit_c    = 1'b0;
        grow_eff_c = grow_pending | GROW;
        frozen_c   = SELF_HIT | WALL_HIT;

        // Opposite directions differ in both encoding bits.
        if ((NAV_STATE ^ cur_dir) == 2'b11) begin
            new_dir_c = cur_dir;
        end

        case (new_dir_c)
            DIR_UP: begin
                if (seg_y[0] == Y_W'(0)) begin
                    off_grid_c = 1'b1;
                    next_y_c   = Y_W'(GRID_H - 1);
                end else begin
                    next_y_c = seg_y[0] - Y_W'(1);
                end
            end
            DIR_DOWN: begin
                if (seg_y[0] == Y_W'(GRID_H - 1)) begin
                    off_grid_c = 1'b1;
                    next_y_c   = Y_W'(0);
                end else begin
                    next_y_c = seg_y[0] + Y_W'(1);
                end
            end
            DIR_LEFT: begin
                if (seg_x[0] == X_W'(0)) begin
                    off_grid_c = 1'b1;
                    next_x_c   = X_W'(GRID_W - 1);
                end else begin
                    next_x_c = seg_x[0] - X_W'(1);
                end
            end
            default: begin
                if (seg_x[0] == X_W'(GRID_W - 1)) begin
                    off_grid_c = 1'b1;
                    next_x_c   = X_W'(0);
                end else begin
                    next_x_c = seg_x[0] + X_W'(1);
                end
            end
        endcase

        wall_stop_c = (WRAP_MODE == 0) && off_grid_c;

        // Without growth the tail cell is vacated by this move, so it is excluded.
        hit_lim_c = grow_eff_c ? LENGTH : (LENGTH - LEN_W'(1));

        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < hit_lim_c) && (seg_x[i] == next_x_c) && (seg_y[i] == next_y_c)) begin
                body_hit_c = 1'b1;
            end
            if ((LEN_W'(i) < LENGTH) && (seg_x[i] == QUERY_X) && (seg_y[i] == QUERY_Y)) begin
                q_hit_c = 1'b1;
            end
        end
    end

    // Segment store, length, direction and status registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_W'(START_X);
                seg_y[i] <= Y_W'(START_Y);
            end
            LENGTH       <= LEN_W'(INIT_LEN);
            cur_dir      <= DIR_RIGHT;
            grow_pending <= 1'b0;
            SELF_HIT     <= 1'b0;
            WALL_HIT     <= 1'b0;
            MOVE_DONE    <= 1'b0;
            QUERY_HIT    <= 1'b0;
            QUERY_HEAD   <= 1'b0;
        end else if (CLEAR) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X_W'(START_X);
                seg_y[i] <= Y_W'(START_Y);
            end
            LENGTH       <= LEN_W'(INIT_LEN);
            cur_dir      <= DIR_RIGHT;
            grow_pending <= 1'b0;
            SELF_HIT     <= 1'b0;
            WALL_HIT     <= 1'b0;
            MOVE_DONE    <= 1'b0;
            QUERY_HIT    <= 1'b0;
            QUERY_HEAD   <= 1'b0;
        end else begin
            MOVE_DONE    <= 1'b0;
            QUERY_HIT    <= q_hit_c;
            QUERY_HEAD   <= (seg_x[0] == QUERY_X) && (seg_y[0] == QUERY_Y);
            grow_pending <= grow_eff_c;
            if (STEP) begin
                cur_dir <= new_dir_c;
                if (!frozen_c) begin
                    if (wall_stop_c) begin
                        WALL_HIT <= 1'b1;
                    end else begin
                        for (int unsigned i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0] <= next_x_c;
                        seg_y[0] <= next_y_c;
                        if (body_hit_c) begin
                            SELF_HIT <= 1'b1;
                        end
                        if (grow_eff_c && (LENGTH < LEN_W'(MAX_LEN))) begin
                            LENGTH <= LENGTH + LEN_W'(1);
                        end
                        grow_pending <= 1'b0;
                        MOVE_DONE    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed testbench for snake_body_engine: a wrapping default instance and a
// walled, MAX_LEN=4 instance started next to the right edge.
module tb_snake_body_engine;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       stp_a, grow_a, stp_b, grow_b;
    logic [1:0] nav_a, nav_b;
    logic [7:0] qx;
    logic [6:0] qy;

    logic       a_qhit, a_qhead, a_self, a_wall, a_md;
    logic [7:0] a_hx;
    logic [6:0] a_hy;
    logic [5:0] a_len;

    logic       b_qhit, b_qhead, b_self, b_wall, b_md;
    logic [7:0] b_hx;
    logic [6:0] b_hy;
    logic [5:0] b_len;

    int n_cmp = 0;
    int n_err = 0;

    snake_body_engine u_wrap (
        .CLK(clk), .RESET(rst), .CLEAR(clear), .STEP(stp_a), .NAV_STATE(nav_a), .GROW(grow_a),
        .QUERY_X(qx), .QUERY_Y(qy), .QUERY_HIT(a_qhit), .QUERY_HEAD(a_qhead),
        .HEAD_X(a_hx), .HEAD_Y(a_hy), .LENGTH(a_len),
        .SELF_HIT(a_self), .WALL_HIT(a_wall), .MOVE_DONE(a_md)
    );

    snake_body_engine #(.MAX_LEN(4), .WRAP_MODE(0), .START_X(158), .START_Y(1)) u_wall (
        .CLK(clk), .RESET(rst), .CLEAR(clear), .STEP(stp_b), .NAV_STATE(nav_b), .GROW(grow_b),
        .QUERY_X(qx), .QUERY_Y(qy), .QUERY_HIT(b_qhit), .QUERY_HEAD(b_qhead),
        .HEAD_X(b_hx), .HEAD_Y(b_hy), .LENGTH(b_len),
        .SELF_HIT(b_self), .WALL_HIT(b_wall), .MOVE_DONE(b_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic [1:0] nav, input logic g);
        nav_a = nav; grow_a = g; stp_a = 1'b1;
        @(posedge clk); #1;
        stp_a = 1'b0; grow_a = 1'b0;
    endtask

    task automatic step_b(input logic [1:0] nav, input logic g);
        nav_b = nav; grow_b = g; stp_b = 1'b1;
        @(posedge clk); #1;
        stp_b = 1'b0; grow_b = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic head_a(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(a_hx), 32'(x));
        check({tag, "_y"}, 32'(a_hy), 32'(y));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        stp_a = 1'b0; grow_a = 1'b0; nav_a = 2'b10;
        stp_b = 1'b0; grow_b = 1'b0; nav_b = 2'b10;
        qx = 8'd0; qy = 7'd0;
        #12 rst = 1'b0;
        #1;

        // Reset state
        head_a("rst_head", 80, 100);
        check("rst_len", 32'(a_len), 2);
        check("rst_self", 32'(a_self), 0);
        check("rst_md", 32'(a_md), 0);
        check("rst_qhit", 32'(a_qhit), 0);
        check("rst_b_hx", 32'(b_hx), 158);

        // Walled instance: grow, saturate at 4, then strike the right wall
        step_b(2'b11, 1'b1);
        check("b_len3", 32'(b_len), 3);
        step_b(2'b11, 1'b1);
        check("b_len4", 32'(b_len), 4);
        step_b(2'b11, 1'b1);
        check("b_len_sat", 32'(b_len), 4);
        check("b_sat_md", 32'(b_md), 1);
        check("b_sat_hy", 32'(b_hy), 4);
        step_b(2'b10, 1'b0);
        check("b_edge_hx", 32'(b_hx), 159);
        step_b(2'b10, 1'b0);
        check("b_wall", 32'(b_wall), 1);
        check("b_wall_hx", 32'(b_hx), 159);
        check("b_wall_md", 32'(b_md), 0);
        check("b_wall_len", 32'(b_len), 4);
        step_b(2'b00, 1'b0);
        check("b_frozen_hy", 32'(b_hy), 4);
        check("b_frozen_wall", 32'(b_wall), 1);

        // Three moves right, one MOVE_DONE each
        for (int i = 0; i < 3; i++) begin
            step_a(2'b10, 1'b0);
            check("md_pulse", 32'(a_md), 1);
        end
        idle();
        check("md_low", 32'(a_md), 0);
        head_a("mv3", 83, 100);
        check("mv3_len", 32'(a_len), 2);

        // Registered query
        qx = 8'd82; qy = 7'd100; idle();
        check("q82_hit", 32'(a_qhit), 1);
        check("q82_head", 32'(a_qhead), 0);
        qx = 8'd83; idle();
        check("q83_hit", 32'(a_qhit), 1);
        check("q83_head", 32'(a_qhead), 1);
        qx = 8'd81; idle();
        check("q81_hit", 32'(a_qhit), 0);

        // Reversal suppressed, then a legal turn up
        step_a(2'b01, 1'b0);
        head_a("rev", 84, 100);
        step_a(2'b00, 1'b0);
        head_a("turn_up", 84, 99);

        // Five moves with GROW
        for (int i = 0; i < 5; i++) step_a(2'b00, 1'b1);
        check("grow_len", 32'(a_len), 7);
        head_a("grow", 84, 94);

        // Wrap through the top edge
        for (int i = 0; i < 94; i++) step_a(2'b00, 1'b0);
        head_a("top", 84, 0);
        step_a(2'b00, 1'b0);
        head_a("wrap_y", 84, 119);

        // Wrap through the right edge
        for (int i = 0; i < 75; i++) step_a(2'b10, 1'b0);
        head_a("right", 159, 119);
        step_a(2'b10, 1'b0);
        head_a("wrap_x", 0, 119);
        check("wrap_self", 32'(a_self), 0);

        // Restart, grow to 5 and turn back into the body
        clear = 1'b1; idle(); clear = 1'b0;
        for (int i = 0; i < 3; i++) step_a(2'b10, 1'b1);
        check("sh_len", 32'(a_len), 5);
        step_a(2'b00, 1'b0);
        step_a(2'b01, 1'b0);
        check("sh_none", 32'(a_self), 0);
        step_a(2'b11, 1'b0);
        check("sh_hit", 32'(a_self), 1);
        check("sh_md", 32'(a_md), 1);
        head_a("sh", 82, 100);
        step_a(2'b10, 1'b0);
        check("sh_sticky", 32'(a_self), 1);
        check("sh_frz_md", 32'(a_md), 0);
        head_a("sh_frz", 82, 100);

        // CLEAR out of the frozen state
        qx = 8'd80; qy = 7'd100;
        clear = 1'b1; idle(); clear = 1'b0;
        check("clr_self", 32'(a_self), 0);
        check("clr_len", 32'(a_len), 2);
        head_a("clr", 80, 100);
        check("clr_qhit", 32'(a_qhit), 0);
        check("clr_md", 32'(a_md), 0);
        idle();
        check("post_clr_qhit", 32'(a_qhit), 1);
        check("post_clr_qhead", 32'(a_qhead), 1);

        // Length-4 square loop chasing the vacating tail
        step_a(2'b10, 1'b1);
        step_a(2'b10, 1'b1);
        check("sq_len", 32'(a_len), 4);
        step_a(2'b00, 1'b0);
        step_a(2'b01, 1'b0);
        step_a(2'b11, 1'b0);
        step_a(2'b10, 1'b0);
        check("sq_tail_ok", 32'(a_self), 0);
        head_a("sq", 82, 100);
        step_a(2'b00, 1'b1);
        check("sq_grow_hit", 32'(a_self), 1);
        check("sq_grow_len", 32'(a_len), 5);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        check("arst_self", 32'(a_self), 0);
        check("arst_len", 32'(a_len), 2);
        head_a("arst", 80, 100);
        check("arst_b_wall", 32'(b_wall), 0);
        #1 rst = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
Parametrised snake body store and movement engine. It is the successor to the fixed 20-segment snake logic, with configurable grid, length limit and wall/wrap mode. It also adds self-collision and wall-collision detection, reversal suppression and a registered per-pixel occupancy query. It sits between the navigation state machine and the VGA colour mux; the master state machine drives CLEAR/STEP/GROW.

Parameters:
MAX_LEN, 32, maximum segment count (>= INIT_LEN+1, <= 2**LEN_W-1)
INIT_LEN, 2, length after reset/CLEAR (>= 2)
LEN_W, 6, width of LENGTH
GRID_W, 160, columns; X range 0..GRID_W-1
GRID_H, 120, rows; Y range 0..GRID_H-1
X_W, 8, X coordinate width
Y_W, 7, Y coordinate width
WRAP_MODE, 1, 1 = wrap at edges; 0 = edges are walls
START_X, 80, initial column of every segment
START_Y, 100, initial row of every segment

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
CLEAR  in  1  synchronous restart to initial state
STEP  in  1  one-cycle move tick (from speed counter)
NAV_STATE  in  2  requested direction: 00 up, 01 left, 10 right, 11 down
GROW  in  1  one-cycle pulse: target eaten
QUERY_X  in  X_W  cell column under test (pixel ADDRH[9:2])
QUERY_Y  in  Y_W  cell row under test (pixel ADDRY[8:2])
QUERY_HIT  out  1  query cell occupied by any active segment (registered)
QUERY_HEAD  out  1  query cell equals head (registered)
HEAD_X  out  X_W  head column
HEAD_Y  out  Y_W  head row
LENGTH  out  LEN_W  active segment count
SELF_HIT  out  1  sticky: head moved onto body
WALL_HIT  out  1  sticky: wall struck (WRAP_MODE=0 only)
MOVE_DONE  out  1  one-cycle pulse after each accepted move

Behaviour:
- Reset (async) and CLEAR (sync, priority over all other inputs): all segments = (START_X, START_Y); LENGTH = INIT_LEN; current direction = right (10); grow_pending = 0; SELF_HIT = WALL_HIT = MOVE_DONE = QUERY_HIT = QUERY_HEAD = 0.
- Direction: on each STEP, NAV_STATE is adopted unless it is the exact reverse of the current direction (up<->down, left<->right). A reversal request keeps the previous direction.
- GROW sets grow_pending; GROW and STEP in the same cycle count as pending for that step.
- Move on STEP, only when SELF_HIT=0 and WALL_HIT=0 (frozen otherwise):
  - Compute next head. Wrap: 0-1 -> GRID_W-1/GRID_H-1, and GRID_W-1+1 -> 0 (likewise for Y).
  - WRAP_MODE=0 and the move leaves the grid: set WALL_HIT; no shift, no length change, no MOVE_DONE.
  - Self-check: compare next head with segments 0..LENGTH-2 when not growing (tail vacates), or 0..LENGTH-1 when growing. A match sets SELF_HIT and the move still commits.
  - Commit: segment[i+1] <= segment[i] for all i < MAX_LEN-1; segment[0] <= next head.
  - If grow_pending: LENGTH <= LENGTH+1, saturating at MAX_LEN (pending consumed either way). Then MOVE_DONE = 1 for the next cycle.
- Segments with index >= LENGTH are ignored by the query and collision logic.
- Query: 1-cycle latency. QUERY_HIT(t+1) = OR over i<LENGTH of (seg[i]==query at t); QUERY_HEAD(t+1) = (seg[0]==query at t). Values reflect segment contents before any same-cycle STEP.
- Sticky flags clear only on RESET/CLEAR; a GROW while frozen is retained as pending.
- Reset asserted mid-move: all state returns to initial values immediately, with no partial shift.

Test Plan:
- Reset, then 3 STEPs with NAV=10 -> HEAD=(83,100), LENGTH=2, 3 MOVE_DONE pulses; query (82,100) -> QUERY_HIT=1, QUERY_HEAD=0 one cycle later; query (81,100) -> 0.
- WRAP_MODE=1, head at (159,y), NAV=10, STEP -> HEAD_X=0. Head at (x,0), NAV=00 -> HEAD_Y=119. WRAP_MODE=0, same edge -> WALL_HIT=1, head unchanged, further STEPs ignored.
- Moving right, NAV=01, STEP -> head continues right (reversal suppressed); then NAV=00 -> head Y decrements.
- GROW with STEP same cycle ×5 from LENGTH=2 -> LENGTH=7; MAX_LEN=4 build with repeated GROW -> LENGTH saturates at 4.
- Length 5, path up, left, down, right into own neck -> SELF_HIT=1 and latched. Length 4 head chasing vacating tail (square loop) -> no SELF_HIT without GROW; with GROW on that step -> SELF_HIT=1.
- CLEAR during a frozen SELF_HIT state -> all outputs back to reset values; async RESET pulse between clock edges -> outputs reset before the next edge.
